// File: rtl/spi_receiver.sv
// SPI mode-0 slave: deserializes one DAC channel (sclk/mosi/cs) into parallel words.
// All pins are asynchronous; they are synchronized, edge-detected and fed to a 3-state FSM.
module spi_receiver #(
   parameter int unsigned DATA_LENGTH = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   clock_in,
   input  logic                   reset_in,
   input  logic                   sclk_in,
   input  logic                   mosi_in,
   input  logic                   cs_in,
   output logic [DATA_LENGTH-1:0] data_out,
   output logic                   data_valid_out,
   output logic                   frame_error_out,
   output logic                   busy_out,
   output logic [15:0]            word_count_out
);

   localparam int unsigned CntW   = $clog2(DATA_LENGTH + 2);
   localparam int unsigned FlushW = $clog2(SYNC_STAGES + 2);
   localparam logic [CntW-1:0]   CntMax    = CntW'(DATA_LENGTH + 1);
   localparam logic [CntW-1:0]   CntFull   = CntW'(DATA_LENGTH);
   localparam logic [FlushW-1:0] FlushDone = FlushW'(SYNC_STAGES + 1);

   typedef enum logic [1:0] {StArm, StIdle, StShift} state_e;

   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sclk_prev_q, cs_prev_q;
   logic                   sclk_rise_q, cs_rise_q, cs_fall_q, mosi_q;
   logic                   sclk_s, cs_s, mosi_s;

   state_e                 state_q, state_d;
   logic [DATA_LENGTH-1:0] shift_q, shift_d;
   logic [CntW-1:0]        bit_cnt_q, bit_cnt_d, cnt_next;
   logic [FlushW-1:0]      arm_cnt_q, arm_cnt_d;
   logic [DATA_LENGTH-1:0] data_q, data_d;
   logic                   valid_q, valid_d, err_q, err_d;
   logic [15:0]            word_cnt_q, word_cnt_d;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // Synchronizers, previous-value flops and registered edge strobes (mosi kept aligned).
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         sclk_rise_q <= 1'b0;
         cs_rise_q   <= 1'b0;
         cs_fall_q   <= 1'b0;
         mosi_q      <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_in};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
         sclk_rise_q <= sclk_s & ~sclk_prev_q;
         cs_rise_q   <= cs_s & ~cs_prev_q;
         cs_fall_q   <= ~cs_s & cs_prev_q;
         mosi_q      <= mosi_s;
      end
   end

   // FSM state, shift register, counters and output registers.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q    <= StArm;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         arm_cnt_q  <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         arm_cnt_q  <= arm_cnt_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   // Next-state logic: arm after reset, start on cs fall, shift on sclk rise, judge on cs rise.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      arm_cnt_d  = arm_cnt_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      word_cnt_d = word_cnt_q;
      cnt_next   = bit_cnt_q;
      unique case (state_q)
         StArm: begin
            // Synchronizers reset to idle levels, so wait until they hold real pin values
            // before trusting cs; otherwise a frame in progress at release looks like a new one.
            if (arm_cnt_q != FlushDone) begin
               arm_cnt_d = arm_cnt_q + 1'b1;
            end else if (cs_prev_q) begin
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (cs_fall_q) begin
               shift_d   = '0;
               bit_cnt_d = '0;
               state_d   = StShift;
            end
         end
         StShift: begin
            if (sclk_rise_q) begin
               shift_d = {shift_q[DATA_LENGTH-2:0], mosi_q};
               if (bit_cnt_q != CntMax) begin
                  cnt_next = bit_cnt_q + 1'b1;
               end
            end
            bit_cnt_d = cnt_next;
            // Frame-end check uses the count including a bit shifted this same cycle.
            if (cs_rise_q) begin
               if (cnt_next == CntFull) begin
                  data_d     = shift_d;
                  valid_d    = 1'b1;
                  word_cnt_d = word_cnt_q + 16'd1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = StIdle;
            end
         end
         default: state_d = StArm;
      endcase
   end

   assign data_out        = data_q;
   assign data_valid_out  = valid_q;
   assign frame_error_out = err_q;
   assign busy_out        = (state_q == StShift);
   assign word_count_out  = word_cnt_q;

endmodule

// File: tb/tb_spi_receiver.sv
// Scoreboard bench for spi_receiver: stimulus pushes expected pulses, a monitor pops and compares.
module tb_spi_receiver;

   localparam int unsigned DL = 16;
   localparam int unsigned SS = 2;
   localparam int Latency = SS + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sclk = 1'b0;
   logic          mosi = 1'b0;
   logic          cs = 1'b1;
   logic [DL-1:0] data_out;
   logic          dv, fe, busy;
   logic [15:0]   wc;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      logic        is_err;
      logic [15:0] data;
      logic [15:0] wc;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   logic [15:0] exp_data = 16'h0;
   logic [15:0] exp_wc   = 16'h0;
   logic        prev_pulse = 1'b0;

   spi_receiver #(
      .DATA_LENGTH (DL),
      .SYNC_STAGES (SS)
   ) dut (
      .clock_in        (clk),
      .reset_in        (rst),
      .sclk_in         (sclk),
      .mosi_in         (mosi),
      .cs_in           (cs),
      .data_out        (data_out),
      .data_valid_out  (dv),
      .frame_error_out (fe),
      .busy_out        (busy),
      .word_count_out  (wc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one frame MSB first; the expected pulse is queued at the cs rise.
   task automatic send_frame(input logic [31:0] word, input int nbits, input int half,
                             input int gap);
      exp_t e;
      cs = 1'b0;
      wait_cyc(2);
      for (int i = nbits - 1; i >= 0; i--) begin
         mosi = word[i];
         wait_cyc(half);
         sclk = 1'b1;
         wait_cyc(half);
         sclk = 1'b0;
         if (i == nbits - 3) check("busy_mid_frame", {31'd0, busy}, 32'd1);
      end
      wait_cyc(half);
      cs = 1'b1;
      if (nbits == int'(DL)) begin
         exp_data = word[15:0];
         exp_wc   = exp_wc + 16'd1;
         e.is_err = 1'b0;
      end else begin
         e.is_err = 1'b1;
      end
      e.data = exp_data;
      e.wc   = exp_wc;
      e.cyc  = cyc + Latency;
      sb.push_back(e);
      wait_cyc(gap);
   endtask

   // Monitor: every pulse must match the head of the scoreboard, in kind, value and timing.
   always @(negedge clk) begin
      if (!rst) begin
         if (dv && fe) begin
            n_tests++; n_fail++;
            $display("FAIL pulse_exclusive: valid=%0b error=%0b, expected not both", dv, fe);
         end
         if ((dv || fe) && prev_pulse) begin
            n_tests++; n_fail++;
            $display("FAIL pulse_width: pulse high two cycles, expected one");
         end
         if (dv || fe) begin
            if (sb.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_pulse: valid=%0b error=%0b, expected none", dv, fe);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("pulse_is_error", {31'd0, fe}, {31'd0, e.is_err});
               check("pulse_data_out", {16'd0, data_out}, {16'd0, e.data});
               check("pulse_word_count", {16'd0, wc}, {16'd0, e.wc});
               check("pulse_latency_cycle", cyc, e.cyc);
            end
         end
      end
      prev_pulse = !rst && (dv || fe);
   end

   initial begin
      int budget;
      wait_cyc(3);
      rst = 1'b0;
      #1;
      check("reset_data_out", {16'd0, data_out}, 32'd0);
      check("reset_valid", {31'd0, dv}, 32'd0);
      check("reset_error", {31'd0, fe}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_word_count", {16'd0, wc}, 32'd0);
      wait_cyc(8);

      // Basic frame, slow sclk
      send_frame(32'hA5C3, 16, 4, 8);
      check("t1_data", {16'd0, data_out}, 32'hA5C3);
      check("t1_wc", {16'd0, wc}, 32'd1);

      // Good frame then a short frame
      send_frame(32'h1234, 16, 2, 8);
      send_frame(32'h7ABC, 15, 2, 8);
      check("t2_data_held", {16'd0, data_out}, 32'h1234);
      check("t2_wc_held", {16'd0, wc}, 32'd2);

      // Overrun frame
      send_frame(32'h1_5555, 17, 2, 8);
      check("t3_data_held", {16'd0, data_out}, 32'h1234);
      check("t3_busy_idle", {31'd0, busy}, 32'd0);

      // Back-to-back frames with a 2-cycle cs-high gap
      send_frame(32'h0000, 16, 2, 2);
      send_frame(32'hFFFF, 16, 2, 8);
      check("t4_data", {16'd0, data_out}, 32'hFFFF);
      check("t4_wc", {16'd0, wc}, 32'd4);

      // Reset after bit 8, cs still low at release
      cs = 1'b0;
      wait_cyc(2);
      for (int i = 0; i < 8; i++) begin
         mosi = i[0];
         wait_cyc(2); sclk = 1'b1;
         wait_cyc(2); sclk = 1'b0;
      end
      rst = 1'b1;
      wait_cyc(3);
      rst = 1'b0;
      exp_data = 16'h0;
      exp_wc   = 16'h0;
      #1;
      check("t5_data_reset", {16'd0, data_out}, 32'd0);
      check("t5_wc_reset", {16'd0, wc}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         mosi = ~i[0];
         wait_cyc(2); sclk = 1'b1;
         wait_cyc(2); sclk = 1'b0;
      end
      check("t5_armed_not_busy", {31'd0, busy}, 32'd0);
      wait_cyc(2);
      cs = 1'b1;
      wait_cyc(8);
      check("t5_still_idle", {31'd0, busy}, 32'd0);
      send_frame(32'hBEEF, 16, 2, 8);
      check("t5_data", {16'd0, data_out}, 32'hBEEF);
      check("t5_wc", {16'd0, wc}, 32'd1);

      // Loopback-style word with MSB and LSB set
      send_frame(32'h8001, 16, 2, 8);
      check("t6_data", {16'd0, data_out}, 32'h8001);
      check("t6_wc", {16'd0, wc}, 32'd2);

      budget = 50;
      while (sb.size() != 0 && budget > 0) begin
         wait_cyc(1);
         budget--;
      end
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
